// File: rtl/vram_fill_arbiter.sv
// Screen RAM port B arbiter: CPU bus accesses (fixed priority) and a
// constant-byte fill engine that paints a wrap-around range one byte per cycle.
module vram_fill_arbiter #(
  parameter logic [15:0] VRAM_BASE = 16'h0200,
  parameter logic [15:0] REG_BASE  = 16'h0600
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        rw,
  input  logic [7:0]  ram_q,
  output logic [9:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_wren,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        busy,
  output logic        fill_irq
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  start_q, start_d;
  logic [9:0]  len_q, len_d;
  logic [7:0]  value_q, value_d;
  logic [9:0]  addr_q, addr_d;
  logic [9:0]  remain_q, remain_d;
  logic [7:0]  fval_q, fval_d;
  logic        done_q, done_d;
  logic        irq_q, irq_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rd_vram_q, rd_vram_d;

  logic [15:0] vram_off, reg_off;
  logic        vram_hit, reg_hit, reg_wr, reg_rd, start_req;

  // Unsigned wrap of the subtraction makes a single compare cover both bounds.
  assign vram_off  = cpu_addr - VRAM_BASE;
  assign reg_off   = cpu_addr - REG_BASE;
  assign vram_hit  = cpu_req && (vram_off < 16'd1024);
  assign reg_hit   = cpu_req && (reg_off < 16'd6);
  assign reg_wr    = reg_hit && !rw;
  assign reg_rd    = reg_hit && rw;
  assign start_req = reg_wr && (reg_off[2:0] == 3'd5) && cpu_wdata[0];

  assign busy     = (state_q == S_RUN);
  assign fill_irq = irq_q;
  assign cpu_rvalid = rvalid_q;
  // ram_q is already registered inside the RAM, so a VRAM read forwards it directly.
  assign cpu_rdata  = rd_vram_q ? ram_q : rdata_q;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if (reset) begin
      ram_wren = 1'b0;
    end else if (vram_hit) begin
      ram_addr  = vram_off[9:0];
      ram_wdata = cpu_wdata;
      ram_wren  = ~rw;
    end else if (state_q == S_RUN) begin
      ram_addr  = addr_q;
      ram_wdata = fval_q;
      ram_wren  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    len_d     = len_q;
    value_d   = value_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    fval_d    = fval_q;
    done_d    = done_q;
    irq_d     = 1'b0;
    rdata_d   = '0;
    rvalid_d  = (vram_hit || reg_hit) && rw;
    rd_vram_d = vram_hit && rw;

    if (reg_wr) begin
      case (reg_off[2:0])
        3'd0:    start_d[7:0] = cpu_wdata;
        3'd1:    start_d[9:8] = cpu_wdata[1:0];
        3'd2:    len_d[7:0]   = cpu_wdata;
        3'd3:    len_d[9:8]   = cpu_wdata[1:0];
        3'd4:    value_d      = cpu_wdata;
        default: ;
      endcase
    end

    if (reg_rd) begin
      case (reg_off[2:0])
        3'd0:    rdata_d = start_q[7:0];
        3'd1:    rdata_d = {6'b0, start_q[9:8]};
        3'd2:    rdata_d = len_q[7:0];
        3'd3:    rdata_d = {6'b0, len_q[9:8]};
        3'd4:    rdata_d = value_q;
        3'd5: begin
          rdata_d = {6'b0, done_q, busy};
          done_d  = 1'b0;
        end
        default: rdata_d = '0;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d  = S_RUN;
          addr_d   = start_q;
          remain_d = len_q;
          fval_d   = value_q;
          done_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (!vram_hit) begin
          addr_d   = addr_q + 10'd1;
          remain_d = remain_q - 10'd1;
          if (remain_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            irq_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      len_q     <= '0;
      value_q   <= '0;
      addr_q    <= '0;
      remain_q  <= '0;
      fval_q    <= '0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rd_vram_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      len_q     <= len_d;
      value_q   <= value_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      fval_q    <= fval_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rd_vram_q <= rd_vram_d;
    end
  end

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Directed bench for vram_fill_arbiter: synchronous RAM model, port B write log,
// hand-computed expectations for fills, wrap, contention, restart and reset.
module tb_vram_fill_arbiter;

  localparam logic [15:0] REG = 16'h0600;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        rw;
  logic [7:0]  ram_q;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_wren;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        busy;
  logic        fill_irq;

  vram_fill_arbiter #(.VRAM_BASE(16'h0200), .REG_BASE(16'h0600)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .rw(rw), .ram_q(ram_q), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wren(ram_wren), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .busy(busy), .fill_irq(fill_irq)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {int cyc; int addr; int data; bit cpu;} wr_t;

  logic [7:0] mem [1024];
  wr_t        wlog[$];
  int         irqs[$];
  int         cyc = 0;
  int         busy_cnt;
  int         fall_cyc;
  bit         prev_busy = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  always @(negedge CLOCK_50) begin
    if (ram_wren) begin
      wr_t w;
      w.cyc  = cyc;
      w.addr = int'(ram_addr);
      w.data = int'(ram_wdata);
      w.cpu  = cpu_req && (cpu_addr >= 16'h0200) && (cpu_addr <= 16'h05FF);
      wlog.push_back(w);
    end
    if (fill_irq) irqs.push_back(cyc);
    if (busy) busy_cnt++;
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit req, input bit r, input logic [15:0] a, input logic [7:0] d);
    @(posedge CLOCK_50);
    #1;
    reset     = 1'b0;
    cpu_req   = req;
    rw        = r;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, 16'h0000, 8'h00);
  endtask

  task automatic bus_read(input logic [15:0] a, output int d, output int v);
    drive(1'b1, 1'b1, a, 8'h00);
    drive(1'b0, 1'b1, 16'h0000, 8'h00);
    d = int'(cpu_rdata);
    v = int'(cpu_rvalid);
  endtask

  task automatic set_fill(input logic [9:0] s, input logic [9:0] l, input logic [7:0] v);
    drive(1'b1, 1'b0, REG + 16'd0, s[7:0]);
    drive(1'b1, 1'b0, REG + 16'd1, {6'b0, s[9:8]});
    drive(1'b1, 1'b0, REG + 16'd2, l[7:0]);
    drive(1'b1, 1'b0, REG + 16'd3, {6'b0, l[9:8]});
    drive(1'b1, 1'b0, REG + 16'd4, v);
    idle(1);
  endtask

  task automatic start_fill(output int t);
    wlog.delete();
    irqs.delete();
    busy_cnt = 0;
    fall_cyc = -1;
    drive(1'b1, 1'b0, REG + 16'd5, 8'h01);
    t = cyc;
  endtask

  function automatic int eng_count();
    int n = 0;
    foreach (wlog[i]) if (!wlog[i].cpu) n++;
    return n;
  endfunction

  function automatic int wfield(input int idx, input int f);
    if (idx >= wlog.size()) return -1;
    case (f)
      0: return wlog[idx].cyc;
      1: return wlog[idx].addr;
      2: return wlog[idx].data;
      default: return int'(wlog[idx].cpu);
    endcase
  endfunction

  function automatic int irq0();
    return (irqs.size() > 0) ? irqs[0] : -1;
  endfunction

  initial begin
    int t, d, v, bad;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset = 1'b1; cpu_req = 1'b0; rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_eq("rst_ram_addr", int'(ram_addr), 0);
    check_eq("rst_ram_wdata", int'(ram_wdata), 0);
    check_eq("rst_ram_wren", int'(ram_wren), 0);
    check_eq("rst_cpu_rdata", int'(cpu_rdata), 0);
    check_eq("rst_cpu_rvalid", int'(cpu_rvalid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_fill_irq", int'(fill_irq), 0);
    idle(2);

    // Register readback and unused bits
    drive(1'b1, 1'b0, REG + 16'd0, 8'hA5);
    drive(1'b1, 1'b0, REG + 16'd1, 8'hFF);
    drive(1'b1, 1'b0, REG + 16'd3, 8'hFE);
    bus_read(REG + 16'd0, d, v);
    check_eq("reg0_rd", d, 8'hA5);
    check_eq("reg0_rvalid", v, 1);
    bus_read(REG + 16'd1, d, v);
    check_eq("reg1_rd_masked", d, 8'h03);
    bus_read(REG + 16'd3, d, v);
    check_eq("reg3_rd_masked", d, 8'h02);

    // CPU VRAM write/read and out-of-window access
    drive(1'b1, 1'b0, 16'h0234, 8'h3C);
    bus_read(16'h0234, d, v);
    check_eq("vram_rd_data", d, 8'h3C);
    check_eq("vram_rd_valid", v, 1);
    bus_read(16'h1000, d, v);
    check_eq("oow_rvalid", v, 0);

    // Single-byte fill at the top address
    set_fill(10'h3FF, 10'h000, 8'hAA);
    start_fill(t);
    idle(6);
    check_eq("single_count", wlog.size(), 1);
    check_eq("single_cyc", wfield(0, 0), t + 1);
    check_eq("single_addr", wfield(0, 1), 10'h3FF);
    check_eq("single_data", wfield(0, 2), 8'hAA);
    check_eq("single_busy_fall", fall_cyc, t + 2);
    check_eq("single_irq_n", irqs.size(), 1);
    check_eq("single_irq_cyc", irq0(), t + 2);

    // Wrap-around
    set_fill(10'h3FE, 10'h003, 8'h55);
    start_fill(t);
    idle(8);
    check_eq("wrap_count", wlog.size(), 4);
    check_eq("wrap_a0", wfield(0, 1), 10'h3FE);
    check_eq("wrap_a1", wfield(1, 1), 10'h3FF);
    check_eq("wrap_a2", wfield(2, 1), 10'h000);
    check_eq("wrap_a3", wfield(3, 1), 10'h001);
    check_eq("wrap_c3", wfield(3, 0), t + 4);
    check_eq("wrap_no_002", int'(mem[2]), 0);
    check_eq("wrap_irq_cyc", irq0(), t + 5);

    // Contention: CPU writes to RAM 0x010 in T+2 and T+3
    set_fill(10'h100, 10'h00F, 8'h77);
    start_fill(t);
    idle(1);
    drive(1'b1, 1'b0, 16'h0210, 8'hC3);
    drive(1'b1, 1'b0, 16'h0210, 8'hC4);
    idle(25);
    check_eq("cont_total", wlog.size(), 18);
    check_eq("cont_eng", eng_count(), 16);
    check_eq("cont_cpu_cyc", wfield(1, 0), t + 2);
    check_eq("cont_cpu_addr", wfield(1, 1), 10'h010);
    check_eq("cont_cpu_data", wfield(2, 2), 8'hC4);
    check_eq("cont_hold_addr", wfield(3, 1), 10'h101);
    check_eq("cont_hold_cyc", wfield(3, 0), t + 4);
    check_eq("cont_last_cyc", wfield(17, 0), t + 18);
    check_eq("cont_irq_cyc", irq0(), t + 19);

    // Full screen
    set_fill(10'h123, 10'h3FF, 8'h5A);
    start_fill(t);
    idle(1030);
    check_eq("full_count", wlog.size(), 1024);
    check_eq("full_first_addr", wfield(0, 1), 10'h123);
    check_eq("full_last_addr", wfield(1023, 1), 10'h122);
    check_eq("full_last_cyc", wfield(1023, 0), t + 1024);
    check_eq("full_busy_cycles", busy_cnt, 1024);
    check_eq("full_irq_cyc", irq0(), t + 1025);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h5A) bad++;
    check_eq("full_mem_bad", bad, 0);
    bus_read(REG + 16'd5, d, v);
    check_eq("full_ctrl_rd1", d, 8'h02);
    bus_read(REG + 16'd5, d, v);
    check_eq("full_ctrl_rd2", d, 8'h00);

    // Start and VALUE/START rewrites while busy
    set_fill(10'h040, 10'h007, 8'h11);
    start_fill(t);
    idle(2);
    drive(1'b1, 1'b0, REG + 16'd5, 8'h01);
    drive(1'b1, 1'b0, REG + 16'd4, 8'h99);
    drive(1'b1, 1'b0, REG + 16'd0, 8'h00);
    idle(10);
    check_eq("busy_count", wlog.size(), 8);
    check_eq("busy_first_addr", wfield(0, 1), 10'h040);
    check_eq("busy_last_addr", wfield(7, 1), 10'h047);
    bad = 0;
    foreach (wlog[i]) if (wlog[i].data != 8'h11) bad++;
    check_eq("busy_data_bad", bad, 0);
    check_eq("busy_irq_n", irqs.size(), 1);
    check_eq("busy_irq_cyc", irq0(), t + 9);
    bus_read(REG + 16'd4, d, v);
    check_eq("busy_value_reg", d, 8'h99);

    // Reset during byte 5 of a 10-byte fill
    set_fill(10'h080, 10'h009, 8'hEE);
    start_fill(t);
    idle(4);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    cpu_req = 1'b0;
    idle(15);
    check_eq("rst_mid_count", wlog.size(), 4);
    check_eq("rst_mid_last_addr", wfield(3, 1), 10'h083);
    check_eq("rst_mid_no_addr84", int'(mem[10'h084]), 8'h5A);
    check_eq("rst_mid_irq_n", irqs.size(), 0);
    check_eq("rst_mid_busy", int'(busy), 0);
    bad = 0;
    for (int r = 0; r < 6; r++) begin
      bus_read(REG + 16'(r), d, v);
      if (d != 0) bad++;
    end
    check_eq("rst_mid_regs_nonzero", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
